// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 message path: FSM states, 32-bit word, block size.
// Also carries the byte-reversal helper used by little-endian message builds.
package sha256_pkg;

    localparam int NUM_WORDS = 16;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic word_t bswap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/msg_addr_counter.sv
// Word counter plus base register for the message fetch; address wraps
// modulo 2^ADDR_W through the natural width of the adder.
module msg_addr_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [3:0]        cnt,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base_q;

    // Word 0 goes out on the load edge itself, so the count resumes at 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            base_q <= base_addr;
            cnt    <= 4'd1;
        end else if (inc) begin
            cnt    <= cnt + 4'd1;
        end
    end

    assign addr = base_q + ADDR_W'(cnt);

endmodule

// File: rtl/msg_word_loader.sv
// Fetches one 16-word SHA-256 block from word memory and streams it out.
// Define MSG_WORD_LOADER_BYTESWAP_EN to byte-reverse words from little-endian memory.
module msg_word_loader #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              busy,
    output logic              word_valid,
    output logic [3:0]        word_index,
    output logic [31:0]       word_data,
    output logic              read_complete
);

    import sha256_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cnt_addr;
    logic              accept;
    logic              issue;
    logic              rd_q;
    word_t             word_in;

    assign accept = (state == IDLE) && start;
    assign issue  = (state == READ) && (cnt != 4'd0);

`ifdef MSG_WORD_LOADER_BYTESWAP_EN
    assign word_in = bswap(mem_rd_data);
`else
    assign word_in = mem_rd_data;
`endif

    msg_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .inc      (issue),
        .base_addr(base_addr),
        .cnt      (cnt),
        .addr     (cnt_addr)
    );

    // Counter wraps to 0 once word 15 is issued, which ends READ.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = READ;
            READ:  if (cnt == 4'd0) state_nx = DRAIN;
            DRAIN: state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE);
            mem_rd_en <= accept || issue;
            if (accept) begin
                mem_addr <= base_addr;
            end else if (issue) begin
                mem_addr <= cnt_addr;
            end
        end
    end

    // Read data lands one cycle after the strobe; rd_q marks it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q          <= 1'b0;
            word_valid    <= 1'b0;
            word_index    <= '0;
            word_data     <= '0;
            read_complete <= 1'b0;
        end else begin
            rd_q          <= mem_rd_en;
            word_valid    <= rd_q;
            read_complete <= word_valid &&
                             (word_index == 4'(NUM_WORDS - 1));
            if (rd_q) begin
                word_data  <= word_in;
                word_index <= word_valid ? word_index + 4'd1 : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_msg_word_loader.sv
// Randomised bench for msg_word_loader with a cycle-offset reference model.
// Honours MSG_WORD_LOADER_BYTESWAP_EN the same way as the design.
module tb_msg_word_loader;

    localparam int ADDR_W = 8;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              busy;
    logic              word_valid;
    logic [3:0]        word_index;
    logic [31:0]       word_data;
    logic              read_complete;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    msg_word_loader #(
        .ADDR_W   (ADDR_W),
        .NUM_WORDS(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy),
        .word_valid   (word_valid),
        .word_index   (word_index),
        .word_data    (word_data),
        .read_complete(read_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory: data visible in the cycle after the strobe.
    initial mem_rd_data = '0;
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef MSG_WORD_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch accepted at edge t0 puts cycle k = edge - t0
    // through a fixed schedule: addr k for k<16, word k-2 for 2..17, done at 18.
    int          ecount = 0;
    int          t0 = -1000;
    bit          active = 1'b0;
    logic [7:0]  mbase = '0;
    logic [7:0]  h_addr = '0;
    logic [31:0] h_data = '0;
    logic [3:0]  h_idx = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            active = 1'b0;
            h_addr = '0;
            h_data = '0;
            h_idx  = '0;
        end else begin
            int k;
            ecount++;
            if (start && (!active || (ecount - 1 - t0) >= 18)) begin
                active = 1'b1;
                t0     = ecount;
                mbase  = base_addr;
            end
            if (active) begin
                k = ecount - t0;
                if (k <= 15) h_addr = 8'(int'(mbase) + k);
                if (k >= 2 && k <= 17) begin
                    h_data = xf(mem[8'(int'(mbase) + k - 2)]);
                    h_idx  = 4'(k - 2);
                end
            end
        end
    end

    always @(negedge clock) begin
        int k;
        k = active ? (ecount - t0) : 1000;
        chk("busy", 32'(busy), 32'(k <= 17));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(k <= 15));
        chk("mem_addr", 32'(mem_addr), 32'(h_addr));
        chk("word_valid", 32'(word_valid), 32'(k >= 2 && k <= 17));
        chk("word_index", 32'(word_index), 32'(h_idx));
        chk("word_data", word_data, h_data);
        chk("read_complete", 32'(read_complete), 32'(k == 18));
    end

    task automatic do_start(input logic [7:0] b);
        @(negedge clock);
        start     = 1'b1;
        base_addr = b;
        @(negedge clock);
        start     = 1'b0;
        base_addr = 8'($urandom);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int rc_cnt;
        int wv_cnt;
        bit found;

        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        for (int a = 0; a < 256; a++) mem[a] = 32'hA5000000 + 32'(a);

        wait_neg(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", word_data, 32'd0);
        reset = 1'b1;
        wait_neg(2);

        // Block at 0x10 with hand-computed values.
        do_start(8'h10);
        chk("lit_addr0", 32'(mem_addr), 32'h10);
        wait_neg(1);
        chk("lit_addr1", 32'(mem_addr), 32'h11);
        wait_neg(1);
        chk("lit_w0", word_data, xf(32'hA5000010));
        wait_neg(15);
        chk("lit_idx15", 32'(word_index), 32'd15);
        chk("lit_w15", word_data, xf(32'hA500001F));
        chk("lit_rc_low", 32'(read_complete), 32'd0);
        wait_neg(1);
        chk("lit_rc18", 32'(read_complete), 32'd1);
        chk("lit_busy18", 32'(busy), 32'd0);
        wait_neg(4);

        // Address wrap from 0xF8.
        do_start(8'hF8);
        wait_neg(8);
        chk("lit_wrap_addr", 32'(mem_addr), 32'h00);
        wait_neg(2);
        chk("lit_wrap_idx", 32'(word_index), 32'd8);
        chk("lit_wrap_w8", word_data, xf(32'hA5000000));
        wait_neg(12);

        // Byte order.
        mem[8'h40] = 32'h11223344;
        do_start(8'h40);
        wait_neg(2);
`ifdef MSG_WORD_LOADER_BYTESWAP_EN
        chk("lit_bswap", word_data, 32'h44332211);
`else
        chk("lit_nobswap", word_data, 32'h11223344);
`endif
        wait_neg(20);

        // Start held high, base changing every cycle.
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        rc_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        for (int j = 0; j < 95; j++) begin
            base_addr = 8'($urandom);
            @(negedge clock);
            if (read_complete) rc_cnt++;
        end
        start = 1'b0;
        chk("b2b_rc_count", 32'(rc_cnt), 32'd5);
        wait_neg(22);

        // Reset in the middle of a fetch.
        do_start(8'($urandom));
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            if (word_valid && word_index == 4'd7) found = 1'b1;
            else @(negedge clock);
        end
        if (!found) begin
            errors++;
            $display("FAIL rst_wait: word 7 never seen");
        end
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_idx", 32'(word_index), 32'd0);
        chk("mid_rst_data", word_data, 32'd0);
        chk("mid_rst_rc", 32'(read_complete), 32'd0);
        wait_neg(3);
        reset = 1'b1;
        wait_neg(25);
        wv_cnt = 0;
        do_start(8'($urandom));
        for (int j = 0; j < 20; j++) begin
            if (word_valid) wv_cnt++;
            @(negedge clock);
        end
        chk("post_rst_words", 32'(wv_cnt), 32'd16);
        wait_neg(5);

        // Random traffic, including starts while busy.
        for (int j = 0; j < 400; j++) begin
            start     = ($urandom_range(0, 3) == 0);
            base_addr = 8'($urandom);
            @(negedge clock);
        end
        start = 1'b0;
        wait_neg(25);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
